rtc_bus_scheduler: RTL and testbench
====================================

# rtc_bus_scheduler

Transaction scheduler between the RTC bus-cycle driver and the rest of the RTC/VGA machine. It sweeps the RTC time, date and timer registers on every refresh tick and commits them atomically to the display registers consumed by the VGA text generator. It also arbitrates write requests from the configuration FSM, which set the date, time or timer, onto the same single RTC bus.

## Interface
Parameters:
- `ADDR_SEG_C`, `8'h21`: clock seconds register
- `ADDR_MIN_C`, `8'h22`: clock minutes
- `ADDR_HORA_C`, `8'h23`: clock hours
- `ADDR_DIA`, `8'h24`: day
- `ADDR_MES`, `8'h25`: month
- `ADDR_YEAR`, `8'h26`: year
- `ADDR_SEG_T`, `8'h41`: timer seconds
- `ADDR_MIN_T`, `8'h42`: timer minutes
- `ADDR_HORA_T`, `8'h43`: timer hours

Ports:
- `clk`  in  1  system clock; the block has one clock domain
- `reset`  in  1  asynchronous, active-high reset
- `refresh_tick`  in  1  one-cycle pulse requesting a read sweep
- `wr_req`  in  1  write request; held by the requester until `wr_ack`
- `wr_addr`  in  8  write target address
- `wr_data`  in  8  write data, BCD
- `wr_ack`  out  1  one-cycle pulse when the write completes
- `alarm_en`  in  1  enables `alarma_signal`
- `bus_req`  out  1  transaction request to the bus driver; held until `bus_done`
- `bus_rd`  out  1  1 = read, 0 = write; valid while `bus_req` is high
- `bus_addr`  out  8  transaction address
- `bus_wdata`  out  8  write data
- `bus_done`  in  1  one-cycle pulse marking the end of a transaction
- `bus_rdata`  in  8  read data, valid in the `bus_done` cycle
- `cambio_dia`, `cambio_mes`, `cambio_year`  out  8 each  committed date
- `hora_c`, `min_c`, `seg_c`  out  8 each  committed clock
- `hora_t`, `min_t`, `seg_t`  out  8 each  committed timer
- `data_valid`  out  1  one-cycle pulse on each commit
- `alarma_signal`  out  1  high while `alarm_en` is set and the committed timer reads 00:00:00

## Operation
- The FSM has six states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, COMMIT.
- Sweep order by index 0–8: seg_c, min_c, hora_c, dia, mes, year, seg_t, min_t, hora_t.
- Each read's `bus_rdata` goes into a shadow register. No output changes mid-sweep.
- IDLE:
  - `wr_req` → WR_ISSUE. Writes have priority.
  - Otherwise, if a tick is pending → RD_ISSUE with index 0.
- RD_ISSUE → RD_WAIT; `bus_req=1`, `bus_rd=1`. RD_WAIT leaves on `bus_done`:
  - If index is 8 → COMMIT.
  - Else if `wr_req` is high → WR_ISSUE. The sweep is aborted and the shadow is discarded.
  - Else → RD_ISSUE with index+1.
- WR_ISSUE → WR_WAIT; `bus_req=1`, `bus_rd=0`. On `bus_done`:
  - Pulse `wr_ack`, set tick-pending, go to IDLE.
  - This forces a fresh full sweep so the display reflects the write.
- COMMIT: copy the shadow to the outputs, pulse `data_valid`, go to IDLE.
- Tick-pending is a one-deep flag:
  - Set by `refresh_tick` in any state.
  - Cleared on entering RD_ISSUE with index 0.
  - Multiple ticks during a sweep collapse into one sweep.
- `wr_addr`/`wr_data` are sampled into `bus_addr`/`bus_wdata` on entry to WR_ISSUE and held through WR_WAIT.
- Write addresses are not validated; an unknown address is written to the bus as given.
- `alarma_signal` is combinational from the committed registers and `alarm_en`. It changes only on commit or on an `alarm_en` change.
- Reset, at any time including mid-transaction:
  - All outputs go to 0 immediately, including `bus_req`, the shadow registers and tick-pending.
  - State goes to IDLE.
  - `alarma_signal` is 0 during reset; afterwards it follows its rule, with `alarm_en` and the zeroed timer.

## Timing
- All outputs are registered except `alarma_signal`.
- `refresh_tick` at cycle t with the FSM in IDLE gives `bus_req` high at t+2: one cycle to latch pending, one for IDLE→RD_ISSUE.
- `bus_req` drops in the cycle after `bus_done`. The next request rises no earlier than 1 cycle later, giving at least one idle cycle between transactions.
- Commit latency: outputs and `data_valid` update 2 cycles after the 9th `bus_done`.
- `wr_ack` is asserted 1 cycle after the write's `bus_done`.
- `wr_req` and `refresh_tick` in the same IDLE cycle: the write is served first, then the sweep.
- `bus_done` is ignored outside RD_WAIT and WR_WAIT.

## Structure
- Shared package `rtc_pkg`:
  - RTC register address constants, the defaults above.
  - FSM state encoding.
  - Sweep length, 9.
- The sweep index → address mapping is a case on the index. No sub-module is needed.
- Integration: the existing RTC bus-cycle driver sits on the `bus_*` side; the VGA text generator consumes the outputs.

## Test plan
- **Single tick, no writes.** Bus model returns 0x05, 0x07, 0x13, 0x15, 0x10, 0x03, 0x06, 0x08, 0x05 with a 4-cycle latency. Required: nine reads in order 0x21–0x26, 0x41–0x43; `seg_c=05`, `min_c=07`, `hora_c=13`, `cambio_dia=15`, `cambio_mes=10`, `cambio_year=03`, `seg_t=06`, `min_t=08`, `hora_t=05`; exactly one `data_valid`; outputs stay 0 until the commit cycle.
- **Write preempts a sweep.** `wr_req` with addr 0x23, data 0x09 during read index 4. Required: index-4 read completes, then the write goes out (`bus_rd=0`, addr 0x23, data 0x09); `wr_ack` pulses; a full new sweep follows; no commit from the aborted sweep.
- **Tick collapse.** Three ticks during one sweep. Required: exactly one extra sweep afterwards, two `data_valid` pulses in total.
- **Alarm.** Timer reads return 00/00/00 with `alarm_en=1`. Required: `alarma_signal=1` from the commit cycle; dropping `alarm_en` clears it combinationally.
- **Reset mid-transaction.** `reset` asserted during RD_WAIT. Required: `bus_req=0` and all outputs 0 in the same cycle; after release there is no bus activity until the next tick.
- **Simultaneous requests.** `wr_req` and `refresh_tick` in the same IDLE cycle. Required: the write transaction precedes the first read.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants for the RTC bus scheduler: register map, sweep length
// and scheduler state encoding.
package rtc_pkg;

    localparam logic [7:0] RTC_ADDR_SEG_C  = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN_C  = 8'h22;
    localparam logic [7:0] RTC_ADDR_HORA_C = 8'h23;
    localparam logic [7:0] RTC_ADDR_DIA    = 8'h24;
    localparam logic [7:0] RTC_ADDR_MES    = 8'h25;
    localparam logic [7:0] RTC_ADDR_YEAR   = 8'h26;
    localparam logic [7:0] RTC_ADDR_SEG_T  = 8'h41;
    localparam logic [7:0] RTC_ADDR_MIN_T  = 8'h42;
    localparam logic [7:0] RTC_ADDR_HORA_T = 8'h43;

    localparam int SWEEP_LEN = 9;
    localparam int IDX_W     = 4;

    typedef logic [IDX_W-1:0] sweep_idx_t;

    localparam sweep_idx_t SWEEP_LAST = sweep_idx_t'(SWEEP_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/rtc_bus_scheduler.sv
// Schedules RTC bus transactions: periodic read sweeps of the time, date and
// timer registers committed atomically to the display outputs, plus
// priority writes from the configuration FSM.
module rtc_bus_scheduler
    import rtc_pkg::*;
#(
    parameter logic [7:0] ADDR_SEG_C  = RTC_ADDR_SEG_C,
    parameter logic [7:0] ADDR_MIN_C  = RTC_ADDR_MIN_C,
    parameter logic [7:0] ADDR_HORA_C = RTC_ADDR_HORA_C,
    parameter logic [7:0] ADDR_DIA    = RTC_ADDR_DIA,
    parameter logic [7:0] ADDR_MES    = RTC_ADDR_MES,
    parameter logic [7:0] ADDR_YEAR   = RTC_ADDR_YEAR,
    parameter logic [7:0] ADDR_SEG_T  = RTC_ADDR_SEG_T,
    parameter logic [7:0] ADDR_MIN_T  = RTC_ADDR_MIN_T,
    parameter logic [7:0] ADDR_HORA_T = RTC_ADDR_HORA_T
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       alarm_en,
    output logic       bus_req,
    output logic       bus_rd,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_done,
    input  logic [7:0] bus_rdata,
    output logic [7:0] cambio_dia,
    output logic [7:0] cambio_mes,
    output logic [7:0] cambio_year,
    output logic [7:0] hora_c,
    output logic [7:0] min_c,
    output logic [7:0] seg_c,
    output logic [7:0] hora_t,
    output logic [7:0] min_t,
    output logic [7:0] seg_t,
    output logic       data_valid,
    output logic       alarma_signal
);

    state_t                          state, next_state;
    sweep_idx_t                      idx;
    logic                            tick_pending;
    logic [SWEEP_LEN-1:0][7:0]       shadow;

    logic bus_req_next;
    logic start_sweep;
    logic next_read;
    logic enter_wr;
    logic rd_done;
    logic wr_done;
    logic do_commit;

    function automatic logic [7:0] sweep_addr(input sweep_idx_t i);
        case (i)
            4'd0:    sweep_addr = ADDR_SEG_C;
            4'd1:    sweep_addr = ADDR_MIN_C;
            4'd2:    sweep_addr = ADDR_HORA_C;
            4'd3:    sweep_addr = ADDR_DIA;
            4'd4:    sweep_addr = ADDR_MES;
            4'd5:    sweep_addr = ADDR_YEAR;
            4'd6:    sweep_addr = ADDR_SEG_T;
            4'd7:    sweep_addr = ADDR_MIN_T;
            4'd8:    sweep_addr = ADDR_HORA_T;
            default: sweep_addr = ADDR_SEG_C;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        next_state   = state;
        bus_req_next = 1'b0;
        start_sweep  = 1'b0;
        next_read    = 1'b0;
        enter_wr     = 1'b0;
        rd_done      = 1'b0;
        wr_done      = 1'b0;
        do_commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                // wr_ack high means the requester has not yet dropped the
                // request it just had served; do not serve it twice.
                if (wr_req && !wr_ack) begin
                    next_state   = ST_WR_ISSUE;
                    enter_wr     = 1'b1;
                    bus_req_next = 1'b1;
                end else if (tick_pending) begin
                    next_state   = ST_RD_ISSUE;
                    start_sweep  = 1'b1;
                    bus_req_next = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                next_state   = ST_RD_WAIT;
                bus_req_next = 1'b1;
            end
            ST_RD_WAIT: begin
                bus_req_next = !bus_done;
                if (bus_done) begin
                    rd_done = 1'b1;
                    if (idx == SWEEP_LAST) begin
                        next_state = ST_COMMIT;
                    end else if (wr_req) begin
                        next_state = ST_WR_ISSUE;
                        enter_wr   = 1'b1;
                    end else begin
                        next_state = ST_RD_ISSUE;
                        next_read  = 1'b1;
                    end
                end
            end
            ST_WR_ISSUE: begin
                next_state   = ST_WR_WAIT;
                bus_req_next = 1'b1;
            end
            ST_WR_WAIT: begin
                bus_req_next = !bus_done;
                if (bus_done) begin
                    wr_done    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                do_commit  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // One-deep refresh request; a write also requests a sweep so the display
    // picks up the new value
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       tick_pending <= 1'b0;
        else if (refresh_tick || wr_done) tick_pending <= 1'b1;
        else if (start_sweep)            tick_pending <= 1'b0;
    end

    // Bus request/address/data registers and read sweep index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_rd    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            idx       <= '0;
            wr_ack    <= 1'b0;
        end else begin
            bus_req <= bus_req_next;
            wr_ack  <= wr_done;
            if (start_sweep) begin
                idx      <= '0;
                bus_rd   <= 1'b1;
                bus_addr <= sweep_addr('0);
            end
            if (next_read) begin
                idx      <= idx + 4'd1;
                bus_rd   <= 1'b1;
                bus_addr <= sweep_addr(idx + 4'd1);
            end
            if (enter_wr) begin
                bus_rd    <= 1'b0;
                bus_addr  <= wr_addr;
                bus_wdata <= wr_data;
            end
        end
    end

    // Shadow capture during the sweep and atomic commit to the display outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow      <= '0;
            data_valid  <= 1'b0;
            seg_c       <= 8'h00;
            min_c       <= 8'h00;
            hora_c      <= 8'h00;
            cambio_dia  <= 8'h00;
            cambio_mes  <= 8'h00;
            cambio_year <= 8'h00;
            seg_t       <= 8'h00;
            min_t       <= 8'h00;
            hora_t      <= 8'h00;
        end else begin
            data_valid <= do_commit;
            if (rd_done) shadow[idx] <= bus_rdata;
            if (do_commit) begin
                seg_c       <= shadow[0];
                min_c       <= shadow[1];
                hora_c      <= shadow[2];
                cambio_dia  <= shadow[3];
                cambio_mes  <= shadow[4];
                cambio_year <= shadow[5];
                seg_t       <= shadow[6];
                min_t       <= shadow[7];
                hora_t      <= shadow[8];
            end
        end
    end

    // Alarm is held low while reset is asserted, otherwise follows the
    // committed timer reaching zero
    assign alarma_signal = alarm_en && !reset &&
                           (hora_t == 8'h00) && (min_t == 8'h00) && (seg_t == 8'h00);

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed self-checking bench for rtc_bus_scheduler with a simple RTC bus
// model (fixed 4-cycle latency, register contents held in mem).
module tb_rtc_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       refresh_tick;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       alarm_en;
    logic       bus_req;
    logic       bus_rd;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_done  = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic [7:0] cambio_dia, cambio_mes, cambio_year;
    logic [7:0] hora_c, min_c, seg_c;
    logic [7:0] hora_t, min_t, seg_t;
    logic       data_valid;
    logic       alarma_signal;

    int n_assert = 0;
    int n_fail   = 0;
    int dv_cnt   = 0;

    logic [7:0] mem [256];
    logic [7:0] log_addr [128];
    logic       log_rd   [128];
    logic [7:0] log_wd   [128];
    int         log_n = 0;
    int         lat   = 0;

    logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                 8'h41, 8'h42, 8'h43};

    rtc_bus_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .alarm_en     (alarm_en),
        .bus_req      (bus_req),
        .bus_rd       (bus_rd),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_done     (bus_done),
        .bus_rdata    (bus_rdata),
        .cambio_dia   (cambio_dia),
        .cambio_mes   (cambio_mes),
        .cambio_year  (cambio_year),
        .hora_c       (hora_c),
        .min_c        (min_c),
        .seg_c        (seg_c),
        .hora_t       (hora_t),
        .min_t        (min_t),
        .seg_t        (seg_t),
        .data_valid   (data_valid),
        .alarma_signal(alarma_signal)
    );

    always #5 clk = ~clk;

    // Bus driver model: bus_done four cycles into a request, logs every transaction
    always @(posedge clk) begin
        #1;
        if (bus_done) begin
            bus_done = 1'b0;
            lat      = 0;
        end else if (bus_req) begin
            lat = lat + 1;
            if (lat == 4) begin
                bus_done  = 1'b1;
                bus_rdata = bus_rd ? mem[bus_addr] : 8'h00;
                if (log_n < 128) begin
                    log_addr[log_n] = bus_addr;
                    log_rd[log_n]   = bus_rd;
                    log_wd[log_n]   = bus_wdata;
                end
                log_n = log_n + 1;
                lat   = 0;
            end
        end else begin
            lat = 0;
        end
    end

    // Count commit pulses
    always @(posedge clk) begin
        #2;
        if (data_valid) dv_cnt = dv_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_log(input int n);
        int c = 0;
        while (log_n < n && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (log_n < n) chk("wait_log_timeout", 32'(log_n), 32'(n));
    endtask

    task automatic chk_sweep(input int start, input string tag);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_rd%0d", tag, i), 32'(log_rd[start+i]), 32'd1);
            chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[start+i]), 32'(exp_addr[i]));
        end
    endtask

    task automatic tick();
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int base2;
        int c;

        reset        = 1'b1;
        refresh_tick = 1'b0;
        wr_req       = 1'b0;
        wr_addr      = 8'h00;
        wr_data      = 8'h00;
        alarm_en     = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h05; mem[8'h22] = 8'h07; mem[8'h23] = 8'h13;
        mem[8'h24] = 8'h15; mem[8'h25] = 8'h10; mem[8'h26] = 8'h03;
        mem[8'h41] = 8'h06; mem[8'h42] = 8'h08; mem[8'h43] = 8'h05;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_seg_c", 32'(seg_c), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_alarma", 32'(alarma_signal), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_req", 32'(bus_req), 32'd0);

        // Single tick, no writes
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        chk("tick_req_t1", 32'(bus_req), 32'd0);
        @(negedge clk);
        chk("tick_req_t2", 32'(bus_req), 32'd1);
        chk("tick_rd_t2", 32'(bus_rd), 32'd1);
        chk("tick_addr_t2", 32'(bus_addr), 32'h21);
        wait_log(9);
        chk("mid_seg_c", 32'(seg_c), 32'd0);
        chk("mid_hora_t", 32'(hora_t), 32'd0);
        @(negedge clk);
        chk("pre_commit_dv", 32'(data_valid), 32'd0);
        chk("pre_commit_min_c", 32'(min_c), 32'd0);
        @(negedge clk);
        chk("commit_dv", 32'(data_valid), 32'd1);
        chk("seg_c", 32'(seg_c), 32'h05);
        chk("min_c", 32'(min_c), 32'h07);
        chk("hora_c", 32'(hora_c), 32'h13);
        chk("cambio_dia", 32'(cambio_dia), 32'h15);
        chk("cambio_mes", 32'(cambio_mes), 32'h10);
        chk("cambio_year", 32'(cambio_year), 32'h03);
        chk("seg_t", 32'(seg_t), 32'h06);
        chk("min_t", 32'(min_t), 32'h08);
        chk("hora_t", 32'(hora_t), 32'h05);
        @(negedge clk);
        chk("dv_one_cycle", 32'(data_valid), 32'd0);
        chk("dv_count_1", 32'(dv_cnt), 32'd1);
        chk_sweep(0, "sweep1");

        // Write preempts a sweep during read index 4
        base = log_n;
        tick();
        wait_log(base + 4);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 8'h23;
        wr_data = 8'h09;
        wait_log(base + 6);
        chk("pre_rd4_rd", 32'(log_rd[base+4]), 32'd1);
        chk("pre_rd4_addr", 32'(log_addr[base+4]), 32'h25);
        chk("pre_wr_rd", 32'(log_rd[base+5]), 32'd0);
        chk("pre_wr_addr", 32'(log_addr[base+5]), 32'h23);
        chk("pre_wr_data", 32'(log_wd[base+5]), 32'h09);
        chk("pre_wr_ack_d", 32'(wr_ack), 32'd0);
        @(negedge clk);
        chk("pre_wr_ack_d1", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        mem[8'h23] = 8'h09;
        @(negedge clk);
        chk("pre_wr_ack_pulse", 32'(wr_ack), 32'd0);
        chk("pre_no_abort_commit", 32'(dv_cnt), 32'd1);
        wait_log(base + 15);
        chk_sweep(base + 6, "resweep");
        @(negedge clk);
        @(negedge clk);
        chk("resweep_dv", 32'(data_valid), 32'd1);
        chk("resweep_hora_c", 32'(hora_c), 32'h09);
        chk("resweep_seg_c", 32'(seg_c), 32'h05);
        @(negedge clk);
        chk("dv_count_2", 32'(dv_cnt), 32'd2);

        // Tick collapse: three ticks during one sweep
        base = log_n;
        tick();
        wait_log(base + 2);
        tick();
        wait_log(base + 4);
        tick();
        wait_log(base + 6);
        tick();
        wait_log(base + 18);
        repeat (40) @(negedge clk);
        chk("collapse_txn_count", 32'(log_n), 32'(base + 18));
        chk("collapse_dv_count", 32'(dv_cnt), 32'd4);
        chk("collapse_2nd_first", 32'(log_addr[base+9]), 32'h21);

        // Alarm on zero timer
        mem[8'h41] = 8'h00; mem[8'h42] = 8'h00; mem[8'h43] = 8'h00;
        alarm_en = 1'b1;
        #1;
        chk("alarm_nonzero_timer", 32'(alarma_signal), 32'd0);
        @(negedge clk);
        base = log_n;
        tick();
        wait_log(base + 9);
        chk("alarm_before_commit", 32'(alarma_signal), 32'd0);
        @(negedge clk);
        chk("alarm_commit_state", 32'(alarma_signal), 32'd0);
        @(negedge clk);
        chk("alarm_dv", 32'(data_valid), 32'd1);
        chk("alarm_set", 32'(alarma_signal), 32'd1);
        chk("alarm_seg_t", 32'(seg_t), 32'h00);
        alarm_en = 1'b0;
        #1;
        chk("alarm_en_off", 32'(alarma_signal), 32'd0);
        alarm_en = 1'b1;
        #1;
        chk("alarm_en_on", 32'(alarma_signal), 32'd1);
        @(negedge clk);

        // Reset during RD_WAIT with a tick pending
        base = log_n;
        tick();
        wait_log(base + 1);
        tick();
        wait_log(base + 2);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_req_before", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
        chk("mid_rst_seg_c", 32'(seg_c), 32'd0);
        chk("mid_rst_min_c", 32'(min_c), 32'd0);
        chk("mid_rst_dia", 32'(cambio_dia), 32'd0);
        chk("mid_rst_year", 32'(cambio_year), 32'd0);
        chk("mid_rst_dv", 32'(data_valid), 32'd0);
        chk("mid_rst_alarma", 32'(alarma_signal), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_alarma", 32'(alarma_signal), 32'd1);
        base2 = log_n;
        repeat (30) @(negedge clk);
        chk("post_rst_no_txn", 32'(log_n), 32'(base2));
        chk("post_rst_no_req", 32'(bus_req), 32'd0);

        // Simultaneous write and tick in IDLE
        alarm_en     = 1'b0;
        base         = log_n;
        wr_req       = 1'b1;
        wr_addr      = 8'h41;
        wr_data      = 8'h30;
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        c = 0;
        while (!wr_ack && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!wr_ack) chk("sim_wr_ack_timeout", 32'(wr_ack), 32'd1);
        chk("sim_wr_first_count", 32'(log_n), 32'(base + 1));
        chk("sim_wr_rd", 32'(log_rd[base]), 32'd0);
        chk("sim_wr_addr", 32'(log_addr[base]), 32'h41);
        chk("sim_wr_data", 32'(log_wd[base]), 32'h30);
        wr_req = 1'b0;
        mem[8'h41] = 8'h30;
        wait_log(base + 10);
        chk_sweep(base + 1, "sim_sweep");
        @(negedge clk);
        @(negedge clk);
        chk("sim_dv", 32'(data_valid), 32'd1);
        chk("sim_seg_t", 32'(seg_t), 32'h30);
        chk("sim_hora_c", 32'(hora_c), 32'h09);
        chk("sim_seg_c", 32'(seg_c), 32'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
